aes_iter_core: RTL
==================

Name: aes_iter_core

Overview:
Parametrised iterative AES-128/192/256 encryption core. It is the successor to the fixed-key AES-128 top level. Key size is chosen at elaboration, and the round-key schedule is precomputed from a run-time loaded key into internal storage. Each cycle executes one full round (SubBytes, ShiftRows, MixColumns, AddRoundKey). Valid/ready handshakes on both sides allow it to sit between a block source and a cipher sink.

Parameters:
KEY_BITS, 128, key length; legal values 128/192/256, anything else is an elaboration error. Derived: Nk = KEY_BITS/32 (4/6/8), Nr = Nk+6 (10/12/14), NW = 4*(Nr+1) round-key words (44/52/60).

Ports:
i_clock  in  1  sole clock, rising edge
i_reset  in  1  asynchronous, active-high reset
i_key_load  in  1  one-cycle request to load i_key and expand it
i_key  in  KEY_BITS  cipher key; MSB byte = key byte 0
o_key_ready  out  1  round-key schedule valid
i_valid  in  1  plaintext block offered
o_ready  out  1  core accepts a block this cycle
i_plain  in  128  plaintext; [127:120] = state byte 0, column-major as FIPS-197
o_valid  out  1  o_cipher holds a completed block
i_out_ready  in  1  sink accepts o_cipher
o_cipher  out  128  ciphertext, same byte order as i_plain

Behaviour:
- Reset (async assert, sync release): o_key_ready=0, o_valid=0, o_cipher=0, o_ready=0. Both FSMs go to idle, the round counter is 0, and round-key storage is cleared. Reset mid-expansion or mid-block aborts without output. The key must be reloaded after reset.
- Key FSM states: K_IDLE, K_EXPAND.
  - i_key_load is accepted while the data FSM is in D_IDLE, in either key state. A load during K_EXPAND restarts expansion with the new key.
  - i_key_load is ignored in D_ROUND or D_OUT.
  - Load edge: w[0..Nk-1] <= i_key, o_key_ready <= 0, i <= Nk, go to K_EXPAND.
  - K_EXPAND writes one word per cycle per FIPS-197:
    - temp = w[i-1]
    - if i mod Nk == 0: temp = SubWord(RotWord(temp)) ^ Rcon[i/Nk]
    - else if Nk == 8 and i mod 8 == 4: temp = SubWord(temp)
    - w[i] = w[i-Nk] ^ temp
  - Rcon sequence: 01,02,04,08,10,20,40,80,1b,36.
  - After writing w[NW-1]: o_key_ready <= 1, return to K_IDLE. o_key_ready rises NW-Nk cycles (40/46/52) after the load edge.
- o_ready = o_key_ready & (data state == D_IDLE) & !i_key_load. Key load has priority over block acceptance in the same cycle.
- Data FSM states: D_IDLE, D_ROUND, D_OUT.
  - D_IDLE, on i_valid & o_ready: state <= i_plain ^ rk[0], round <= 1, go to D_ROUND.
  - D_ROUND, each cycle: state <= AddRoundKey(MixColumns(ShiftRows(SubBytes(state))), rk[round]). MixColumns is skipped when round == Nr.
  - D_ROUND, when round == Nr: load the result into o_cipher, set o_valid <= 1, go to D_OUT. Otherwise round <= round+1.
  - rk[r] = {w[4r], w[4r+1], w[4r+2], w[4r+3]}, with w[4r] the MSB word.
  - D_OUT: o_valid and o_cipher are held stable until i_out_ready. On o_valid & i_out_ready: o_valid <= 0, go to D_IDLE.
  - o_ready is 0 throughout D_ROUND and D_OUT; there are no overlapping blocks.
- Latency: o_valid rises Nr cycles after the accepting edge. Minimum block period with i_out_ready held high is Nr+2 cycles.
- i_plain is sampled only on the accept edge. i_key is sampled only on the load edge. Later changes to either have no effect.
- i_valid while o_key_ready=0: not accepted, the block waits, no error.
- GF(2^8) arithmetic: xtime = {b[6:0],1'b0} ^ (b[7] ? 8'h1b : 0). S-box implemented as a 256-entry combinational table, shared by the data path (16 copies) and the key path (4 copies).
- Round counter is 4 bits wide. Word index is 6 bits wide.

Test Plan:
- KEY_BITS=128: load key 2b7e151628aed2a6abf7158809cf4f3c, wait for o_key_ready (40 cycles), send 3243f6a8885a308d313198a2e0370734 -> o_cipher=3925841d02dc09fbdc118597196a0b32, o_valid 10 cycles after accept.
- KEY_BITS=128/192/256 (separate elaborations): key 000102…0f / …17 / …1f, plain 00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a / dda97ca4864cdfe06eaf70a0ec0d7191 / 8ea2b7ca516745bfeafc49904b496089. o_key_ready at 40/46/52 cycles, o_valid at 10/12/14 cycles.
- Backpressure: hold i_out_ready=0 for 20 cycles after o_valid -> o_cipher stable, o_ready=0, a new i_valid is not accepted. Release -> one-cycle handshake, o_ready high the next cycle.
- Back-to-back: i_valid held with 4 blocks, i_out_ready=1 -> all correct, accept edges exactly Nr+2 cycles apart.
- Key priority and re-key: assert i_key_load with i_valid in the same idle cycle -> no accept, o_key_ready drops. A second i_key_load during expansion restarts it; the ciphertext matches the second key. i_key_load during D_ROUND is ignored; the block completes with the old key.
- Reset: assert i_reset mid-round and mid-expansion -> o_valid=0, o_key_ready=0, o_ready=0, o_cipher=0 immediately. Block accepted after reload yields the correct ciphertext.

Source files
------------

// File: rtl/aes_iter_core.sv
// Iterative AES-128/192/256 encryption core: one full round per cycle, with the
// round-key schedule expanded one word per cycle into local storage after each key load.
module aes_iter_core #(
    parameter int KEY_BITS = 128
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_key_load,
    input  logic [KEY_BITS-1:0] i_key,
    output logic                o_key_ready,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [127:0]        i_plain,
    output logic                o_valid,
    input  logic                i_out_ready,
    output logic [127:0]        o_cipher
);
    localparam int NK = KEY_BITS / 32;
    localparam int NR = NK + 6;
    localparam int NW = 4 * (NR + 1);

    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("aes_iter_core: KEY_BITS must be 128, 192 or 256");
    end

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic logic [7:0] rcon(input logic [5:0] idx);
        case (idx)
            6'd1:    return 8'h01;
            6'd2:    return 8'h02;
            6'd3:    return 8'h04;
            6'd4:    return 8'h08;
            6'd5:    return 8'h10;
            6'd6:    return 8'h20;
            6'd7:    return 8'h40;
            6'd8:    return 8'h80;
            6'd9:    return 8'h1b;
            6'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Byte i of the state sits at bits [127-8i -: 8]; column c holds bytes 4c..4c+3.
    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                               input logic last);
        logic [7:0]   sb [16];
        logic [7:0]   sr [16];
        logic [7:0]   mc [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) sb[i] = SBOX[s[127-8*i -: 8]];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) sr[4*c+r] = sb[4*((c+r)%4)+r];
        for (int c = 0; c < 4; c++) begin
            a0 = sr[4*c]; a1 = sr[4*c+1]; a2 = sr[4*c+2]; a3 = sr[4*c+3];
            mc[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            mc[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            mc[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            mc[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = last ? sr[i] : mc[i];
        return res ^ rk;
    endfunction

    typedef enum logic {K_IDLE, K_EXPAND} key_state_t;
    typedef enum logic [1:0] {D_IDLE, D_ROUND, D_OUT} data_state_t;

    key_state_t   key_state_q, key_state_d;
    data_state_t  data_state_q, data_state_d;
    logic [31:0]  w_q [NW];
    logic [31:0]  w_d [NW];
    logic [5:0]   widx_q, widx_d;
    logic         key_ready_q, key_ready_d;
    logic [3:0]   round_q, round_d;
    logic [127:0] state_q, state_d;
    logic [127:0] cipher_q, cipher_d;
    logic         valid_q, valid_d;

    logic         load_ok;
    logic [5:0]   wmod, wdiv, rk_base;
    logic [31:0]  w_prev, w_rot, w_sub, w_temp;
    logic [127:0] rk_cur, round_out;

    assign o_ready     = key_ready_q && (data_state_q == D_IDLE) && !i_key_load;
    assign o_key_ready = key_ready_q;
    assign o_valid     = valid_q;
    assign o_cipher    = cipher_q;

    // Key schedule: one new word w[widx] per cycle while expanding.
    always_comb begin
        key_state_d = key_state_q;
        key_ready_d = key_ready_q;
        widx_d      = widx_q;
        w_d         = w_q;
        load_ok     = i_key_load && (data_state_q == D_IDLE);
        wmod        = widx_q % 6'(NK);
        wdiv        = widx_q / 6'(NK);
        w_prev      = w_q[widx_q - 6'd1];
        w_rot       = (wmod == 6'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
        w_sub       = sub_word(w_rot);
        if (wmod == 6'd0)                  w_temp = w_sub ^ {rcon(wdiv), 24'h0};
        else if (NK == 8 && wmod == 6'd4)  w_temp = w_sub;
        else                               w_temp = w_prev;
        if (load_ok) begin
            for (int k = 0; k < NK; k++) w_d[k] = i_key[KEY_BITS-1-32*k -: 32];
            key_ready_d = 1'b0;
            widx_d      = 6'(NK);
            key_state_d = K_EXPAND;
        end else if (key_state_q == K_EXPAND) begin
            w_d[widx_q] = w_q[widx_q - 6'(NK)] ^ w_temp;
            if (widx_q == 6'(NW - 1)) begin
                key_ready_d = 1'b1;
                key_state_d = K_IDLE;
            end else begin
                widx_d = widx_q + 6'd1;
            end
        end
    end

    always_comb begin
        data_state_d = data_state_q;
        round_d      = round_q;
        state_d      = state_q;
        cipher_d     = cipher_q;
        valid_d      = valid_q;
        rk_base      = {round_q, 2'b00};
        rk_cur       = {w_q[rk_base], w_q[rk_base + 6'd1], w_q[rk_base + 6'd2], w_q[rk_base + 6'd3]};
        round_out    = aes_round(state_q, rk_cur, round_q == 4'(NR));
        case (data_state_q)
            D_IDLE: if (i_valid && o_ready) begin
                state_d      = i_plain ^ {w_q[0], w_q[1], w_q[2], w_q[3]};
                round_d      = 4'd1;
                data_state_d = D_ROUND;
            end
            D_ROUND: begin
                state_d = round_out;
                if (round_q == 4'(NR)) begin
                    cipher_d     = round_out;
                    valid_d      = 1'b1;
                    data_state_d = D_OUT;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            D_OUT: if (i_out_ready) begin
                valid_d      = 1'b0;
                data_state_d = D_IDLE;
            end
            default: data_state_d = D_IDLE;
        endcase
    end

    // Word index parks at NK in reset so the w[i-1]/w[i-Nk] reads stay in range.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            key_state_q  <= K_IDLE;
            data_state_q <= D_IDLE;
            for (int k = 0; k < NW; k++) w_q[k] <= 32'h0;
            widx_q       <= 6'(NK);
            key_ready_q  <= 1'b0;
            round_q      <= 4'd0;
            state_q      <= 128'h0;
            cipher_q     <= 128'h0;
            valid_q      <= 1'b0;
        end else begin
            key_state_q  <= key_state_d;
            data_state_q <= data_state_d;
            w_q          <= w_d;
            widx_q       <= widx_d;
            key_ready_q  <= key_ready_d;
            round_q      <= round_d;
            state_q      <= state_d;
            cipher_q     <= cipher_d;
            valid_q      <= valid_d;
        end
    end
endmodule
